gigatron_uart_loader: RTL

- Upstream stage of the gigatron core: receives a program image over a UART line and writes it, word by word, into the 16-bit program ROM that the core fetches via pc/rom_i.
- Holds the core in reset while loading and releases it after a successful load.
- Lets the team reload ROM images on the board without resynthesis.

---
 rtl/gigatron_uart_loader.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/gigatron_uart_loader.sv
// gigatron_uart_loader: receives a program image over an 8N1 UART line and
// writes it word by word into the core's 16-bit program ROM, holding the core
// in reset while loading.
// Frame: A5, LEN_H, LEN_L, LEN x (lo, hi) [, CSUM]
// Optional build macro LOADER_CHECKSUM_EN adds the trailing CSUM byte check
// (8-bit sum of LEN_H, LEN_L and all data bytes).
//
// state | meaning
// IDLE  | waiting for 0xA5, core running (or released after reset)
// LEN_H | expecting length high byte
// LEN_L | expecting length low byte
// D_LO  | expecting data word low byte
// D_HI  | expecting data word high byte, write issued on receipt
// CSUM  | expecting checksum byte (LOADER_CHECKSUM_EN only)
// FAIL  | last load failed, core held in reset until a new 0xA5
module gigatron_uart_loader #(
   parameter int CLKS_PER_BIT = 217,
   parameter int GAP_TIMEOUT  = 2500000
) (
   input  logic        clock,
   input  logic        rst_n,
   input  logic        rx,
   output logic [15:0] prog_a,
   output logic [15:0] prog_d,
   output logic        prog_we,
   output logic        cpu_rst_n,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam int HALF_BIT = CLKS_PER_BIT / 2;

   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

   typedef enum logic [2:0] {
      IDLE, LEN_H, LEN_L, D_LO, D_HI,
`ifdef LOADER_CHECKSUM_EN
      CSUM,
`endif
      FAIL
   } state_t;

   logic        rx_s1, rx_s2;
   rx_state_t   rx_state, rx_next;
   logic [15:0] bit_cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shreg;
   logic        byte_valid, frame_err;

   state_t      state, state_next;
   logic        do_start, do_write, do_finish, do_fail, gap_exp, fin_pend;
   logic [31:0] gap_cnt;
   logic [7:0]  len_h, lo_byte;
   logic [15:0] words_left, addr;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]  csum;
`endif

   // receiver state sequencing: start check, 8 data bits, stop bit
   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         R_IDLE:  if (!rx_s2) rx_next = R_START;
         R_START: if (bit_cnt == '0) rx_next = rx_s2 ? R_IDLE : R_DATA;
         R_DATA:  if (bit_cnt == '0 && bit_idx == 3'd7) rx_next = R_STOP;
         R_STOP:  if (bit_cnt == '0) rx_next = R_IDLE;
         default: rx_next = R_IDLE;
      endcase
   end

   // synchroniser, bit timer, shift register and byte/framing strobes
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1      <= 1'b1;
         rx_s2      <= 1'b1;
         rx_state   <= R_IDLE;
         bit_cnt    <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_s1      <= rx;
         rx_s2      <= rx_s1;
         rx_state   <= rx_next;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         case (rx_state)
            R_IDLE: begin
               bit_cnt <= 16'(HALF_BIT - 1);
               bit_idx <= '0;
            end
            R_START: bit_cnt <= (bit_cnt == '0) ? 16'(CLKS_PER_BIT - 1) : bit_cnt - 16'd1;
            R_DATA: begin
               if (bit_cnt == '0) begin
                  shreg   <= {rx_s2, shreg[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  bit_cnt <= 16'(CLKS_PER_BIT - 1);
               end else begin
                  bit_cnt <= bit_cnt - 16'd1;
               end
            end
            R_STOP: begin
               if (bit_cnt == '0) begin
                  byte_valid <= rx_s2;
                  frame_err  <= !rx_s2;
               end else begin
                  bit_cnt <= bit_cnt - 16'd1;
               end
            end
            default: bit_cnt <= '0;
         endcase
      end
   end

   // loader next-state and control strobes
   always_comb begin
      state_next = state;
      do_start   = 1'b0;
      do_write   = 1'b0;
      do_finish  = 1'b0;
      do_fail    = 1'b0;
      gap_exp    = (GAP_TIMEOUT != 0) && (gap_cnt == '0) && !byte_valid;
      case (state)
         IDLE, FAIL: begin
            if (byte_valid && shreg == 8'hA5) begin
               do_start   = 1'b1;
               state_next = LEN_H;
            end
         end
         default: begin
            if (frame_err || gap_exp) begin
               do_fail    = 1'b1;
               state_next = FAIL;
            end else if (byte_valid) begin
               case (state)
                  LEN_H: state_next = LEN_L;
                  LEN_L: begin
                     if ({len_h, shreg} == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_next = CSUM;
`else
                        do_finish  = 1'b1;
                        state_next = IDLE;
`endif
                     end else begin
                        state_next = D_LO;
                     end
                  end
                  D_LO: state_next = D_HI;
                  D_HI: begin
                     do_write = 1'b1;
                     if (words_left == 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
                        state_next = CSUM;
`else
                        do_finish  = 1'b1;
                        state_next = IDLE;
`endif
                     end else begin
                        state_next = D_LO;
                     end
                  end
`ifdef LOADER_CHECKSUM_EN
                  CSUM: begin
                     if (shreg == csum) begin
                        do_finish  = 1'b1;
                        state_next = IDLE;
                     end else begin
                        do_fail    = 1'b1;
                        state_next = FAIL;
                     end
                  end
`endif
                  default: state_next = state;
               endcase
            end
         end
      endcase
   end

   // loader state register, counters, ROM write port and status outputs
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         prog_a     <= '0;
         prog_d     <= '0;
         prog_we    <= 1'b0;
         cpu_rst_n  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
         fin_pend   <= 1'b0;
         gap_cnt    <= '0;
         len_h      <= '0;
         lo_byte    <= '0;
         words_left <= '0;
         addr       <= '0;
`ifdef LOADER_CHECKSUM_EN
         csum       <= '0;
`endif
      end else begin
         state    <= state_next;
         prog_we  <= 1'b0;
         fin_pend <= do_finish;
         // done/cpu release lag the final write strobe by one cycle
         if (do_start) begin
            busy  <= 1'b1;
            done  <= 1'b0;
            error <= 1'b0;
            addr  <= '0;
         end else if (do_fail) begin
            busy  <= 1'b0;
            error <= 1'b1;
         end else if (fin_pend) begin
            busy <= 1'b0;
            done <= 1'b1;
         end
         if (do_start)
            cpu_rst_n <= 1'b0;
         else if (state == IDLE)
            cpu_rst_n <= 1'b1;
         if (do_start || byte_valid)
            gap_cnt <= 32'(GAP_TIMEOUT - 1);
         else if (gap_cnt != '0)
            gap_cnt <= gap_cnt - 32'd1;
         if (byte_valid && state == LEN_H) len_h <= shreg;
         if (byte_valid && state == LEN_L) words_left <= {len_h, shreg};
         if (byte_valid && state == D_LO) lo_byte <= shreg;
`ifdef LOADER_CHECKSUM_EN
         if (do_start)
            csum <= '0;
         else if (byte_valid && state inside {LEN_H, LEN_L, D_LO, D_HI})
            csum <= csum + shreg;
`endif
         if (do_write) begin
            prog_a     <= addr;
            prog_d     <= {shreg, lo_byte};
            prog_we    <= 1'b1;
            addr       <= addr + 16'd1;
            words_left <= words_left - 16'd1;
         end
      end
   end

endmodule
